// File: rtl/hazard_pkg.sv
// Shared definitions for hazard_ctrl: FSM state encoding and operand-forward select codes.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } hazard_state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_fwd_sel.sv
// One operand's forward select. Memory has priority over Writeback; x0 is never forwarded.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              i_regwrite_m,
   input  logic [REG_AW-1:0] i_rd_m,
   input  logic              i_regwrite_w,
   input  logic [REG_AW-1:0] i_rd_w,
   input  logic [REG_AW-1:0] i_rs,
   output logic [1:0]        o_fwd
);

   logic w_hit_m;
   logic w_hit_w;

   assign w_hit_m = i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs);
   assign w_hit_w = i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs);
   assign o_fwd   = w_hit_m ? FWD_MEM : (w_hit_w ? FWD_WB : FWD_RF);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use/branch handling, data-memory wait FSM.
// Performance counters are built only when HAZARD_PERF_EN is defined; otherwise tied to 0.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] rs1D,
   input  logic [REG_AW-1:0] rs2D,
   input  logic [REG_AW-1:0] rs1E,
   input  logic [REG_AW-1:0] rs2E,
   input  logic [REG_AW-1:0] rdE,
   input  logic [REG_AW-1:0] rdM,
   input  logic [REG_AW-1:0] rdW,
   input  logic              regwriteM,
   input  logic              regwriteW,
   input  logic              loadE,
   input  logic              pcsrcE,
   input  logic              memreqM,
   input  logic              memreadyM,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              stallM,
   output logic              flushD,
   output logic              flushE,
   output logic              flushW,
   output logic [1:0]        forwardAE,
   output logic [1:0]        forwardBE,
   output logic              mem_err,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt
);

   localparam logic [1:0] S_RUN      = RUN;
   localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
   localparam logic [1:0] S_ERR      = ERR;
   localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

   logic [1:0] r_state;
   logic [1:0] w_next_state;
   logic [7:0] r_wait_cnt;
   logic       w_load_use;
   logic       w_mem_hold;

   hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
      .i_regwrite_m (regwriteM),
      .i_rd_m       (rdM),
      .i_regwrite_w (regwriteW),
      .i_rd_w       (rdW),
      .i_rs         (rs1E),
      .o_fwd        (forwardAE)
   );

   hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
      .i_regwrite_m (regwriteM),
      .i_rd_m       (rdM),
      .i_regwrite_w (regwriteW),
      .i_rd_w       (rdW),
      .i_rs         (rs2E),
      .o_fwd        (forwardBE)
   );

   assign w_load_use = loadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

   // A miss seen in RUN holds the pipe in the same cycle, before MEM_WAIT is entered.
   assign w_mem_hold = !memreadyM &&
                       ((r_state == S_MEM_WAIT) || ((r_state == S_RUN) && memreqM));

   assign mem_err = (r_state == S_ERR);

   always_comb begin
      // NOTE: every output gets a default first so no path through the block infers a latch.
      w_next_state = r_state;
      stallF       = 1'b0;
      stallD       = 1'b0;
      stallE       = 1'b0;
      stallM       = 1'b0;
      flushD       = 1'b0;
      flushE       = 1'b0;
      flushW       = 1'b0;

      case (r_state)
         S_RUN:      if (memreqM && !memreadyM) w_next_state = S_MEM_WAIT;
         S_MEM_WAIT: begin
            if (memreadyM)                       w_next_state = S_RUN;
            else if (r_wait_cnt == TIMEOUT_CNT)  w_next_state = S_ERR;
         end
         S_ERR:      w_next_state = S_ERR;
         default:    w_next_state = S_RUN;
      endcase

      if (r_state == S_ERR) begin
         {stallF, stallD, stallE, stallM} = 4'b1111;
      end else if (w_mem_hold) begin
         {stallF, stallD, stallE, stallM} = 4'b1111;
         flushW = 1'b1;
      end else if (pcsrcE) begin
         flushD = 1'b1;
         flushE = 1'b1;
      end else if (w_load_use) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_MEM_WAIT) r_wait_cnt <= r_wait_cnt + 8'd1;
         else                       r_wait_cnt <= '0;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (stallF) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (flushE) r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus queues hand-computed expectations, a negedge monitor compares.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
   localparam logic [6:0] O_NONE = 7'b0000_000;
   localparam logic [6:0] O_LU   = 7'b1100_010;
   localparam logic [6:0] O_BR   = 7'b0000_110;
   localparam logic [6:0] O_MEM  = 7'b1111_001;
   localparam logic [6:0] O_ERR  = 7'b1111_000;

   typedef struct packed {
      logic [6:0]  stfl;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        merr;
      logic [31:0] sc;
      logic [31:0] fc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic        regwriteM, regwriteW, loadE, pcsrcE, memreqM, memreadyM;
   logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err;
   logic [1:0]  forwardAE, forwardBE;
   logic [31:0] stall_cnt, flush_cnt;

   exp_t  q_exp[$];
   string q_name[$];
   int    n_vec  = 0;
   int    n_fail = 0;
   int    m_sc   = 0;
   int    m_fc   = 0;

   exp_t  mon_e, mon_a;
   string mon_n;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(255)) dut (
      .clk       (clk),
      .reset     (reset),
      .rs1D      (rs1D),
      .rs2D      (rs2D),
      .rs1E      (rs1E),
      .rs2E      (rs2E),
      .rdE       (rdE),
      .rdM       (rdM),
      .rdW       (rdW),
      .regwriteM (regwriteM),
      .regwriteW (regwriteW),
      .loadE     (loadE),
      .pcsrcE    (pcsrcE),
      .memreqM   (memreqM),
      .memreadyM (memreadyM),
      .stallF    (stallF),
      .stallD    (stallD),
      .stallE    (stallE),
      .stallM    (stallM),
      .flushD    (flushD),
      .flushE    (flushE),
      .flushW    (flushW),
      .forwardAE (forwardAE),
      .forwardBE (forwardBE),
      .mem_err   (mem_err),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );

   task automatic clr();
      {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
      {regwriteM, regwriteW, loadE, pcsrcE, memreqM, memreadyM} = '0;
   endtask

   // Queue one cycle's expectation; counter expectations track the cycles already completed.
   task automatic step(input string name, input logic [6:0] stfl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic merr);
      exp_t e;
      if (!reset) begin
         m_sc = 0;
         m_fc = 0;
      end
      e.stfl = stfl;
      e.fa   = fa;
      e.fb   = fb;
      e.merr = merr;
      e.sc   = PERF ? 32'(m_sc) : 32'd0;
      e.fc   = PERF ? 32'(m_fc) : 32'd0;
      q_exp.push_back(e);
      q_name.push_back(name);
      if (reset) begin
         m_sc += int'(stfl[6]);
         m_fc += int'(stfl[1]);
      end
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (q_exp.size() != 0) begin
         mon_e = q_exp.pop_front();
         mon_n = q_name.pop_front();
         mon_a = {stallF, stallD, stallE, stallM, flushD, flushE, flushW,
                  forwardAE, forwardBE, mem_err, stall_cnt, flush_cnt};
         n_vec++;
         if (mon_a !== mon_e) begin
            n_fail++;
            $display("FAIL %s: got st/fl=%b fa=%b fb=%b err=%b sc=%0d fc=%0d, want st/fl=%b fa=%b fb=%b err=%b sc=%0d fc=%0d",
                     mon_n, mon_a.stfl, mon_a.fa, mon_a.fb, mon_a.merr, mon_a.sc, mon_a.fc,
                     mon_e.stfl, mon_e.fa, mon_e.fb, mon_e.merr, mon_e.sc, mon_e.fc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      clr();
      repeat (2) @(posedge clk);
      #1;
      step("reset_state", O_NONE, 2'b00, 2'b00, 1'b0);
      reset = 1'b1;
      step("run_idle", O_NONE, 2'b00, 2'b00, 1'b0);

      // Forwarding
      rdM = 5'd5; regwriteM = 1'b1; rs1E = 5'd5; rdW = 5'd5; regwriteW = 1'b1;
      step("fwd_mem_prio", O_NONE, 2'b10, 2'b00, 1'b0);
      rdM = 5'd0;
      step("fwd_wb_rdm0", O_NONE, 2'b01, 2'b00, 1'b0);
      rdM = 5'd5; rs1E = 5'd3; rdW = 5'd3; rs2E = 5'd5;
      step("fwd_a_wb_b_mem", O_NONE, 2'b01, 2'b10, 1'b0);
      regwriteM = 1'b0; regwriteW = 1'b0; rs1E = 5'd5; rdW = 5'd5;
      step("fwd_no_we", O_NONE, 2'b00, 2'b00, 1'b0);
      regwriteW = 1'b1; rdW = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
      step("fwd_x0", O_NONE, 2'b00, 2'b00, 1'b0);
      clr();

      // Load-use
      loadE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
      step("lu_rs2", O_LU, 2'b00, 2'b00, 1'b0);
      clr();
      step("lu_cnt", O_NONE, 2'b00, 2'b00, 1'b0);
      loadE = 1'b1; rdE = 5'd0; rs1D = 5'd0;
      step("lu_x0", O_NONE, 2'b00, 2'b00, 1'b0);
      loadE = 1'b0; rdE = 5'd7; rs1D = 5'd7;
      step("lu_not_load", O_NONE, 2'b00, 2'b00, 1'b0);
      loadE = 1'b1;
      step("lu_rs1", O_LU, 2'b00, 2'b00, 1'b0);
      clr();

      // Branch, alone and against a load-use hazard
      loadE = 1'b1; rdE = 5'd7; rs2D = 5'd7; pcsrcE = 1'b1;
      step("br_beats_lu", O_BR, 2'b00, 2'b00, 1'b0);
      clr();
      pcsrcE = 1'b1;
      step("br_only", O_BR, 2'b00, 2'b00, 1'b0);
      clr();

      // Hit on first cycle: no wait
      memreqM = 1'b1; memreadyM = 1'b1;
      step("mem_hit", O_NONE, 2'b00, 2'b00, 1'b0);
      clr();
      step("mem_hit_run", O_NONE, 2'b00, 2'b00, 1'b0);

      // Three-cycle wait, branch masked during the hold, applied on the ready cycle
      memreqM = 1'b1; pcsrcE = 1'b1;
      step("memw_c1", O_MEM, 2'b00, 2'b00, 1'b0);
      step("memw_c2", O_MEM, 2'b00, 2'b00, 1'b0);
      step("memw_c3", O_MEM, 2'b00, 2'b00, 1'b0);
      memreadyM = 1'b1;
      step("memw_ready_br", O_BR, 2'b00, 2'b00, 1'b0);
      clr();
      step("memw_back_run", O_NONE, 2'b00, 2'b00, 1'b0);

      // Ready cycle with a load-use hazard on the held Execute contents
      memreqM = 1'b1;
      step("memw2_c1", O_MEM, 2'b00, 2'b00, 1'b0);
      memreadyM = 1'b1; loadE = 1'b1; rdE = 5'd9; rs1D = 5'd9;
      step("memw2_ready_lu", O_LU, 2'b00, 2'b00, 1'b0);
      clr();
      step("memw2_back_run", O_NONE, 2'b00, 2'b00, 1'b0);

      // Timeout: one RUN miss cycle, then wait counts 0..255, then ERR
      memreqM = 1'b1;
      step("to_enter", O_MEM, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 256; i++) step("to_wait", O_MEM, 2'b00, 2'b00, 1'b0);
      step("to_err", O_ERR, 2'b00, 2'b00, 1'b1);
      memreadyM = 1'b1; pcsrcE = 1'b1; loadE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
      step("err_absorb", O_ERR, 2'b00, 2'b00, 1'b1);

      // Asynchronous reset out of ERR, observed before the next rising edge
      reset = 1'b0;
      clr();
      step("err_async_rst", O_NONE, 2'b00, 2'b00, 1'b0);
      reset = 1'b1;
      step("err_rst_run", O_NONE, 2'b00, 2'b00, 1'b0);

      // Asynchronous reset mid-wait
      memreqM = 1'b1;
      step("rstw_c1", O_MEM, 2'b00, 2'b00, 1'b0);
      step("rstw_c2", O_MEM, 2'b00, 2'b00, 1'b0);
      reset = 1'b0;
      memreqM = 1'b0;
      step("rstw_async_rst", O_NONE, 2'b00, 2'b00, 1'b0);
      reset = 1'b1;
      step("rstw_run", O_NONE, 2'b00, 2'b00, 1'b0);
      pcsrcE = 1'b1;
      step("rstw_br_cnt", O_BR, 2'b00, 2'b00, 1'b0);
      clr();
      step("final_cnt", O_NONE, 2'b00, 2'b00, 1'b0);

      @(negedge clk);
      #1;
      n_vec++;
      if (q_exp.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d unchecked expectations, want 0", q_exp.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
